tile_assembler: RTL
===================

# tile_assembler

Upstream stage for `delay_buffer_2d`: collects a stream of N-element rows into a NUM_FEATURES x N tile of PRECISION-bit values and presents the finished tile as one 2-D word. The output has the same shape as the `delay_buffer_2d` input. Input and output both use valid/ready handshakes. A one-tile assembly buffer and a one-tile output register let the next tile fill while the current one waits for acceptance.

## Interface
- NUM_FEATURES, 4, rows per tile (≥1)
- N, 4, elements per row (≥1)
- PRECISION, 4, bits per element
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  row present on in_data
- in_ready  output  1  block can accept a row this cycle
- in_data  input  [PRECISION-1:0] x [N-1:0]  one row
- in_last  input  1  row is the final row of its tile (early close)
- out_valid  output  1  odata holds a complete tile
- out_ready  input  1  consumer accepts the tile this cycle
- odata  output  [PRECISION-1:0] x [NUM_FEATURES-1:0][N-1:0]  assembled tile
- out_rows  output  $clog2(NUM_FEATURES+1)  number of real (non-padded) rows in odata, 1..NUM_FEATURES

## Operation
- State:
  - row counter cnt (0..NUM_FEATURES-1)
  - assembly buffer abuf with flag af (tile complete, awaiting transfer)
  - output register odata/out_rows with flag ov (= out_valid)
- in_ready = !af, driven combinationally from the register.
- Accept: on an edge where in_valid && in_ready:
  - abuf[cnt][i] <= in_data[i] for every i.
  - If cnt == NUM_FEATURES-1 or in_last:
    - rows cnt+1..NUM_FEATURES-1 of abuf <= 0
    - a_rows <= cnt+1
    - af <= 1
    - cnt <= 0
  - Otherwise cnt <= cnt+1.
- Transfer: on an edge where af && (!ov || out_ready):
  - odata <= abuf, out_rows <= a_rows
  - ov <= 1, af <= 0
- Drain: on an edge where ov && out_ready && !af, ov <= 0.
- While out_valid && !out_ready, odata and out_rows stay unchanged.
- Rows are written in arrival order. Row j of a tile lands in odata[j], and element i lands in odata[j][i].
- in_valid while in_ready = 0: no effect. The source must hold in_data and in_last.
- out_ready while out_valid = 0: no effect.
- in_last on the row where cnt == NUM_FEATURES-1 behaves the same as a normal full tile.
- NUM_FEATURES = 1: every accepted row is a complete tile.

## Timing
- Reset (rst_n low, asynchronous):
  - cnt = 0, af = 0, ov = 0
  - abuf, odata and out_rows all zero
  - out_valid = 0, in_ready = 1
  - Any partial tile is discarded. The first row after reset is row 0.
- Latency: the tile-closing row is accepted at edge k, af is set at k, and transfer happens at edge k+1 if the output slot is free or is accepted at k+1. out_valid is therefore high starting at edge k+1.
- in_ready is low for exactly one cycle (between edges k and k+1) when the output slot is free. It stays low until the transfer edge when the slot is blocked.
- Throughput: NUM_FEATURES accepted rows plus one bubble cycle per tile.
- Transfer and drain on the same edge: ov stays 1 and odata gets the new tile, so there is no gap.
- No combinational path from out_ready to in_ready, and none from in_valid to out_valid.

## Test plan
- Reset, then 4 back-to-back rows {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,0} with out_ready = 1 (NUM_FEATURES = N = 4, PRECISION = 4) -> out_valid is a one-cycle pulse one edge after row 3 is accepted; odata[2] = {9,10,11,12}; out_rows = 4; in_ready low for one cycle.
- in_last on the second row, rows {1,1,1,1} and {2,2,2,2} -> odata[0] = 1s, odata[1] = 2s, odata[2] = odata[3] = 0, out_rows = 2; next tile starts at row 0.
- out_ready held 0 while two tiles are streamed -> first tile held stable on odata; second tile fills abuf; in_ready = 0 afterwards; rows offered during stall are not consumed. Raising out_ready for one cycle -> second tile appears on the next edge with out_valid still 1, and in_ready returns to 1.
- Random in_valid/out_ready toggling over 1000 tiles -> every tile matches a scoreboard exactly once, in order, with no loss or duplication.
- rst_n pulsed low after 2 of 4 rows have been accepted -> out_valid = 0 and odata = 0 immediately; the next 4 rows form a clean tile.
- NUM_FEATURES = 1 build, rows {3,...} accepted every other cycle -> out_valid asserts one edge after each acceptance with out_rows = 1.

Source files
------------

// File: rtl/tile_assembler.sv
// rtl/tile_assembler.sv - collects N-element rows into a NUM_FEATURES x N tile with a one-tile output register
module tile_assembler #(
    parameter int NUM_FEATURES = 4,
    parameter int N            = 4,
    parameter int PRECISION    = 4
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [N-1:0][PRECISION-1:0]                    in_data,
    input  logic                                           in_last,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0]  odata,
    output logic [$clog2(NUM_FEATURES+1)-1:0]              out_rows
);

    localparam int CW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int RW = $clog2(NUM_FEATURES + 1);

    typedef logic [N-1:0][PRECISION-1:0] row_t;

    logic [CW-1:0]                cnt_q, cnt_d;
    row_t [NUM_FEATURES-1:0]      abuf_q, abuf_d;
    logic [RW-1:0]                a_rows_q, a_rows_d;
    logic                         af_q, af_d;
    row_t [NUM_FEATURES-1:0]      odata_q, odata_d;
    logic [RW-1:0]                out_rows_q, out_rows_d;
    logic                         ov_q, ov_d;

    logic accept;
    logic close_tile;
    logic transfer;

    assign in_ready  = !af_q;
    assign out_valid = ov_q;
    assign odata     = odata_q;
    assign out_rows  = out_rows_q;

    assign accept     = in_valid && !af_q;
    assign close_tile = (int'(cnt_q) == NUM_FEATURES - 1) || in_last;
    assign transfer   = af_q && (!ov_q || out_ready);

    always_comb begin
        cnt_d      = cnt_q;
        abuf_d     = abuf_q;
        a_rows_d   = a_rows_q;
        af_d       = af_q;
        odata_d    = odata_q;
        out_rows_d = out_rows_q;
        ov_d       = ov_q;

        // Transfer wins over drain so a waiting tile replaces the accepted one with no gap.
        if (transfer) begin
            odata_d    = abuf_q;
            out_rows_d = a_rows_q;
            ov_d       = 1'b1;
            af_d       = 1'b0;
        end else if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end

        // accept implies !af_q, so it never collides with a transfer on the same edge.
        if (accept) begin
            for (int r = 0; r < NUM_FEATURES; r++) begin
                if (r == int'(cnt_q)) begin
                    abuf_d[r] = in_data;
                end else if (close_tile && (r > int'(cnt_q))) begin
                    abuf_d[r] = '0;
                end
            end
            if (close_tile) begin
                a_rows_d = RW'(cnt_q) + RW'(1);
                af_d     = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            abuf_q     <= '0;
            a_rows_q   <= '0;
            af_q       <= 1'b0;
            odata_q    <= '0;
            out_rows_q <= '0;
            ov_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            abuf_q     <= abuf_d;
            a_rows_q   <= a_rows_d;
            af_q       <= af_d;
            odata_q    <= odata_d;
            out_rows_q <= out_rows_d;
            ov_q       <= ov_d;
        end
    end

endmodule
